// File: rtl/booth2_mul_seq_pkg.sv
// Shared definitions for the radix-4 Booth multiply sequencer: FSM encoding, digit count, select codes.
package booth2_mul_seq_pkg;

    localparam int NDIG  = 17;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Booth-2 select codes: {M[2], M[1], M[0]} of the current digit window
    localparam logic [2:0] SEL_ZERO_P = 3'b000;
    localparam logic [2:0] SEL_P1_A   = 3'b001;
    localparam logic [2:0] SEL_P1_B   = 3'b010;
    localparam logic [2:0] SEL_P2     = 3'b011;
    localparam logic [2:0] SEL_M2     = 3'b100;
    localparam logic [2:0] SEL_M1_A   = 3'b101;
    localparam logic [2:0] SEL_M1_B   = 3'b110;
    localparam logic [2:0] SEL_ZERO_N = 3'b111;

endpackage

// File: rtl/booth2_mul_seq_if.sv
// Request/response bundle between the issue logic (master) and the multiply sequencer (slave).
interface booth2_mul_seq_if ();
    logic        start;
    logic        signed_op;
    logic        accum_op;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] addend;
    logic        busy;
    logic        done;
    logic [63:0] result;

    modport master (
        output start, signed_op, accum_op, mcand, mplier, addend,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_op, accum_op, mcand, mplier, addend,
        output busy, done, result
    );
endinterface

// File: rtl/booth2_mul_seq_ppselect.sv
// Booth-2 partial-product selector: picks 0/+-MC/+-2MC; negatives are 1's complement with cin=1.
// Latency: combinational.  Backpressure: none.
// Flow: pure function of mcand/sel, no handshake.
module ppselect
    import booth2_mul_seq_pkg::*;
(
    input  logic [32:0] mcand,
    input  logic [2:0]  sel,
    output logic [33:0] pp,
    output logic        cin
);

    logic [33:0] mag;

    always_comb begin
        mag = '0;
        case (sel)
            SEL_P1_A, SEL_P1_B, SEL_M1_A, SEL_M1_B: mag = {mcand[32], mcand};
            SEL_P2, SEL_M2:                         mag = {mcand, 1'b0};
            default:                                mag = '0;
        endcase
        // 3'b111 yields ~0 + 1 = 0, matching 3'b000
        pp  = sel[2] ? ~mag : mag;
        cin = sel[2];
    end

endmodule

// File: rtl/booth2_mul_seq.sv
// Iterative radix-4 Booth multiply/accumulate, one digit per clock, 64-bit registered result.
// Latency: 18 edges start->done; with MUL_EARLY_TERM_EN, k+1 edges for k digits consumed.
// Backpressure: none; start is only sampled in IDLE (including the done cycle), never queued.
module booth2_mul_seq
    import booth2_mul_seq_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    booth2_mul_seq_if.slave  bus
);

    state_t             state_q,  state_d;
    logic [32:0]        mc_q,     mc_d;
    logic [34:0]        m_q,      m_d;
    logic [34:0]        s_q,      s_d;
    logic [33:0]        l_q,      l_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [63:0]        addend_q, addend_d;
    logic               accum_q,  accum_d;
    logic [63:0]        result_q, result_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;

    logic [33:0]        pp;
    logic               cin;
    logic [34:0]        sum;
    logic [63:0]        prod;

    ppselect u_ppselect (
        .mcand (mc_q),
        .sel   (m_q[2:0]),
        .pp    (pp),
        .cin   (cin)
    );

`ifdef MUL_EARLY_TERM_EN
    logic [CNT_W-1:0]   rem;
    logic [5:0]         shamt;
`endif

    always_comb begin
        sum = s_q + {pp[33], pp} + {34'b0, cin};

`ifdef MUL_EARLY_TERM_EN
        // Unconsumed digits are all zero; realign {S,L} as if they had been shifted in
        rem   = CNT_W'(NDIG) - cnt_q;
        shamt = {rem, 1'b0};
        prod  = 64'($signed({s_q, l_q}) >>> shamt);
`else
        prod  = 64'({s_q, l_q});
`endif

        state_d  = state_q;
        mc_d     = mc_q;
        m_d      = m_q;
        s_d      = s_q;
        l_d      = l_q;
        cnt_d    = cnt_q;
        addend_d = addend_q;
        accum_d  = accum_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mc_d     = {bus.signed_op & bus.mcand[31], bus.mcand};
                    m_d      = {{2{bus.signed_op & bus.mplier[31]}}, bus.mplier, 1'b0};
                    s_d      = '0;
                    l_d      = '0;
                    cnt_d    = '0;
                    addend_d = bus.addend;
                    accum_d  = bus.accum_op;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                s_d   = {sum[34], sum[34], sum[34:2]};
                l_d   = {sum[1:0], l_q[33:2]};
                m_d   = {m_q[34], m_q[34], m_q[34:2]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(NDIG)) begin
                    state_d = ST_FIN;
                end
`ifdef MUL_EARLY_TERM_EN
                else if ((m_d == '0) || (&m_d)) begin
                    state_d = ST_FIN;
                end
`endif
            end
            ST_FIN: begin
                result_d = prod + (accum_q ? addend_q : 64'b0);
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            mc_q     <= '0;
            m_q      <= '0;
            s_q      <= '0;
            l_q      <= '0;
            cnt_q    <= '0;
            addend_q <= '0;
            accum_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_q     <= mc_d;
            m_q      <= m_d;
            s_q      <= s_d;
            l_q      <= l_d;
            cnt_q    <= cnt_d;
            addend_q <= addend_d;
            accum_q  <= accum_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_booth2_mul_seq.sv
// Self-checking bench for booth2_mul_seq: directed corner cases then a randomized sweep against a 64-bit model.
module tb_booth2_mul_seq;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    booth2_mul_seq_if bus ();

    booth2_mul_seq dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Product of the two operands as integers, plus the optional addend, modulo 2^64
    function automatic logic [63:0] ref_result(input bit sgn, input bit acc,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [63:0] add);
        logic [63:0] ea, eb, p;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return p + (acc ? add : 64'b0);
    endfunction

    // Edges from the start-sampling edge to done
    function automatic int ref_latency(input bit sgn, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        longint v;
        longint lim;
        v = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        v = 2 * v;
        for (int k = 1; k < 17; k++) begin
            lim = longint'(1) << (2 * k);
            if (v >= -lim && v < lim) return k + 1;
        end
        return 18;
`else
        if (sgn && b[0] === 1'bx) return 0;
        return 18;
`endif
    endfunction

    task automatic run_op(input string tag, input bit sgn, input bit acc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] add, input bit hold_start,
                          output logic [63:0] res);
        logic [63:0] exp_r;
        int exp_lat;
        int n;
        int extra;
        exp_r   = ref_result(sgn, acc, a, b, add);
        exp_lat = ref_latency(sgn, b);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.accum_op  = acc;
        bus.mcand     = a;
        bus.mplier    = b;
        bus.addend    = add;
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (n < 40) begin
            if (hold_start && n == exp_lat - 1) bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        res = bus.result;
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_r);
        if (hold_start) begin
            chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
            extra = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) extra++;
            end
            chk({tag, "_extra_done"}, 64'(extra), 64'd0);
        end else begin
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] corner_b [4];
        int ndone;
        bit sgn, acc;
        logic [31:0] a, b;

        corner_b[0] = 32'h0000_0000;
        corner_b[1] = 32'h0000_0001;
        corner_b[2] = 32'hFFFF_FFFF;
        corner_b[3] = 32'h8000_0000;

        nreset        = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.accum_op  = 1'b0;
        bus.mcand     = '0;
        bus.mplier    = '0;
        bus.addend    = '0;
        #12;
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_done",   64'(bus.done), 64'd0);
        chk("rst_result", bus.result,    64'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);

        run_op("u_ff_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b0, r);
        chk("u_ff_ff_const", r, 64'hFFFF_FFFE_0000_0001);

        run_op("s_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h0, 1'b0, r);
        chk("s_min_min_const", r, 64'h4000_0000_0000_0000);

        run_op("s_m1_7", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0007, 64'h0, 1'b0, r);
        chk("s_m1_7_const", r, 64'hFFFF_FFFF_FFFF_FFF9);

        run_op("u_acc_wrap", 1'b0, 1'b1, 32'd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r);
        chk("u_acc_wrap_const", r, 64'h0000_0000_0000_0029);

        run_op("u_noacc", 1'b0, 1'b0, 32'd7, 32'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, r);
        chk("u_noacc_const", r, 64'd42);

        run_op("hold_start", 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 64'h0123_4567_89AB_CDEF, 1'b1, r);

        // Reset in the middle of a multiply
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.accum_op  = 1'b0;
        bus.mcand     = 32'hCAFE_F00D;
        bus.mplier    = 32'h7654_3210;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk("midrst_busy",   64'(bus.busy), 64'd0);
        chk("midrst_done",   64'(bus.done), 64'd0);
        chk("midrst_result", bus.result,    64'd0);
        #2;
        nreset = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        run_op("post_rst", 1'b0, 1'b0, 32'hCAFE_F00D, 32'h7654_3210, 64'h0, 1'b0, r);

        run_op("u_x3", 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0003, 64'h0, 1'b0, r);
        chk("u_x3_const", r, 64'h0000_0000_369D_0368);

        for (int i = 0; i < 8; i++) begin
            run_op("corner", bit'(i / 4), bit'(i % 2), $urandom, corner_b[i % 4],
                   {$urandom, $urandom}, 1'b0, r);
        end

        for (int i = 0; i < 40; i++) begin
            sgn = bit'($urandom_range(0, 1));
            acc = bit'($urandom_range(0, 1));
            a   = $urandom;
            case (i % 3)
                0:       b = 32'($urandom_range(0, 255));
                1:       b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                default: b = $urandom;
            endcase
            run_op("rand", sgn, acc, a, b, {$urandom, $urandom}, 1'b0, r);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
